// File: rtl/glip_pattern_endpoint.sv
// Logic-side GLIP traffic endpoint: counter-pattern generator on the
// Logic->Host FIFO and an incrementing-sequence checker on Host->Logic.
module glip_pattern_endpoint #(
    parameter int WIDTH     = 16,
    parameter int ERR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_enable,
    input  logic                 rx_enable,
    output logic                 fifo_out_valid,
    output logic [WIDTH-1:0]     fifo_out_data,
    input  logic                 fifo_out_ready,
    input  logic                 fifo_in_valid,
    input  logic [WIDTH-1:0]     fifo_in_data,
    output logic                 fifo_in_ready,
    output logic [31:0]          tx_count,
    output logic [31:0]          rx_count,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic                 err_seen,
    output logic [WIDTH-1:0]     err_expected,
    output logic [WIDTH-1:0]     err_received
);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SEND  = 2'd1,
        TX_DRAIN = 2'd2
    } tx_state_t;

    typedef enum logic {
        RX_HUNT  = 1'b0,
        RX_TRACK = 1'b1
    } rx_state_t;

    tx_state_t r_tx_state;
    rx_state_t r_rx_state;

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_tx_value;
    logic [31:0]          r_tx_count;
    logic                 r_in_ready;
    logic [WIDTH-1:0]     r_rx_expected;
    logic [31:0]          r_rx_count;
    logic [ERR_WIDTH-1:0] r_err_count;
    logic                 r_err_seen;
    logic [WIDTH-1:0]     r_err_expected;
    logic [WIDTH-1:0]     r_err_received;

    logic w_tx_xfer;
    logic w_rx_xfer;
    logic w_mismatch;
    logic w_err_sat;

    assign w_tx_xfer  = r_out_valid & fifo_out_ready;
    assign w_rx_xfer  = fifo_in_valid & r_in_ready;
    assign w_mismatch = (r_rx_state == RX_TRACK) &&
                        (fifo_in_data != r_rx_expected);
    assign w_err_sat  = &r_err_count;

    // The data register doubles as the pattern value, so it only
    // advances on acceptance and stays stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state  <= TX_IDLE;
            r_out_valid <= 1'b0;
            r_tx_value  <= '0;
            r_tx_count  <= '0;
        end else begin
            unique case (r_tx_state)
                TX_IDLE: begin
                    if (tx_enable) begin
                        r_tx_state  <= TX_SEND;
                        r_out_valid <= 1'b1;
                    end
                end
                TX_SEND: begin
                    if (w_tx_xfer) begin
                        r_tx_count <= r_tx_count + 32'd1;
                        r_tx_value <= r_tx_value + WIDTH'(1);
                        if (!tx_enable) begin
                            r_tx_state  <= TX_IDLE;
                            r_out_valid <= 1'b0;
                        end
                    end else if (!tx_enable) begin
                        r_tx_state <= TX_DRAIN;
                    end
                end
                TX_DRAIN: begin
                    if (w_tx_xfer) begin
                        r_tx_count  <= r_tx_count + 32'd1;
                        r_tx_value  <= r_tx_value + WIDTH'(1);
                        r_tx_state  <= TX_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_tx_state  <= TX_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Expected always resyncs to word+1, which covers seed, match and
    // mismatch alike.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state     <= RX_HUNT;
            r_in_ready     <= 1'b0;
            r_rx_expected  <= '0;
            r_rx_count     <= '0;
            r_err_count    <= '0;
            r_err_seen     <= 1'b0;
            r_err_expected <= '0;
            r_err_received <= '0;
        end else begin
            r_in_ready <= rx_enable;
            if (w_rx_xfer) begin
                r_rx_state    <= RX_TRACK;
                r_rx_count    <= r_rx_count + 32'd1;
                r_rx_expected <= fifo_in_data + WIDTH'(1);
                if (w_mismatch) begin
                    if (!w_err_sat) begin
                        r_err_count <= r_err_count + ERR_WIDTH'(1);
                    end
                    if (!r_err_seen) begin
                        r_err_seen     <= 1'b1;
                        r_err_expected <= r_rx_expected;
                        r_err_received <= fifo_in_data;
                    end
                end
            end
        end
    end

    assign fifo_out_valid = r_out_valid;
    assign fifo_out_data  = r_tx_value;
    assign fifo_in_ready  = r_in_ready;
    assign tx_count       = r_tx_count;
    assign rx_count       = r_rx_count;
    assign err_count      = r_err_count;
    assign err_seen       = r_err_seen;
    assign err_expected   = r_err_expected;
    assign err_received   = r_err_received;

endmodule

// File: tb/tb_glip_pattern_endpoint.sv
// Bench for glip_pattern_endpoint: directed scenarios plus randomized
// traffic checked against a transfer-level reference model.
module tb_glip_pattern_endpoint;

    localparam int W  = 16;
    localparam int EW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_enable = 1'b0;
    logic          rx_enable = 1'b0;
    logic          fifo_out_valid;
    logic [W-1:0]  fifo_out_data;
    logic          fifo_out_ready = 1'b0;
    logic          fifo_in_valid = 1'b0;
    logic [W-1:0]  fifo_in_data = '0;
    logic          fifo_in_ready;
    logic [31:0]   tx_count;
    logic [31:0]   rx_count;
    logic [EW-1:0] err_count;
    logic          err_seen;
    logic [W-1:0]  err_expected;
    logic [W-1:0]  err_received;

    int checks = 0;
    int fails  = 0;

    // Reference model state, advanced once per clock by tick().
    logic          m_valid;
    logic          m_drain;
    logic [W-1:0]  m_tx_val;
    logic [31:0]   m_tx_cnt;
    logic          m_ready;
    logic          m_hunt;
    logic [W-1:0]  m_exp;
    logic [31:0]   m_rx_cnt;
    logic [EW-1:0] m_err;
    logic          m_seen;
    logic [W-1:0]  m_eexp;
    logic [W-1:0]  m_ercv;

    glip_pattern_endpoint #(.WIDTH(W), .ERR_WIDTH(EW)) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_enable     (tx_enable),
        .rx_enable     (rx_enable),
        .fifo_out_valid(fifo_out_valid),
        .fifo_out_data (fifo_out_data),
        .fifo_out_ready(fifo_out_ready),
        .fifo_in_valid (fifo_in_valid),
        .fifo_in_data  (fifo_in_data),
        .fifo_in_ready (fifo_in_ready),
        .tx_count      (tx_count),
        .rx_count      (rx_count),
        .err_count     (err_count),
        .err_seen      (err_seen),
        .err_expected  (err_expected),
        .err_received  (err_received)
    );

    always #5 clk = ~clk;

    task automatic tick();
        if (rst) begin
            m_valid  = 1'b0;
            m_drain  = 1'b0;
            m_tx_val = '0;
            m_tx_cnt = '0;
            m_ready  = 1'b0;
            m_hunt   = 1'b1;
            m_exp    = '0;
            m_rx_cnt = '0;
            m_err    = '0;
            m_seen   = 1'b0;
            m_eexp   = '0;
            m_ercv   = '0;
        end else begin
            if (m_valid && fifo_out_ready) begin
                m_tx_cnt = m_tx_cnt + 1;
                m_tx_val = m_tx_val + 1'b1;
                m_valid  = tx_enable && !m_drain;
                m_drain  = 1'b0;
            end else if (m_valid) begin
                if (!tx_enable) m_drain = 1'b1;
            end else begin
                m_valid = tx_enable;
            end
            if (m_ready && fifo_in_valid) begin
                m_rx_cnt = m_rx_cnt + 1;
                if (!m_hunt && fifo_in_data != m_exp) begin
                    if (m_err != {EW{1'b1}}) m_err = m_err + 1'b1;
                    if (!m_seen) begin
                        m_seen = 1'b1;
                        m_eexp = m_exp;
                        m_ercv = fifo_in_data;
                    end
                end
                m_hunt = 1'b0;
                m_exp  = fifo_in_data + 1'b1;
            end
            m_ready = rx_enable;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic rx_push(input logic [W-1:0] w);
        fifo_in_valid = 1'b1;
        fifo_in_data  = w;
        tick();
        fifo_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        tx_enable = 1'b1;
        fifo_out_ready = 1'b1;
        rx_enable = 1'b1;
        do_reset();
        tx_enable = 1'b0;
        rx_enable = 1'b0;
        fifo_out_ready = 1'b0;
        tick();
        checks++;
        if (fifo_out_valid !== 1'b0 || fifo_out_data !== '0) begin
            fails++;
            $display("FAIL reset_tx got v=%b d=%0h exp v=0 d=0",
                     fifo_out_valid, fifo_out_data);
        end
        checks++;
        if (fifo_in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready got=%b exp=0", fifo_in_ready);
        end
        checks++;
        if (tx_count !== 0 || rx_count !== 0 || err_count !== 0) begin
            fails++;
            $display("FAIL reset_counts got tx=%0d rx=%0d err=%0d exp 0",
                     tx_count, rx_count, err_count);
        end
        checks++;
        if (err_seen !== 1'b0 || err_expected !== '0 ||
            err_received !== '0) begin
            fails++;
            $display("FAIL reset_err got s=%b e=%0h r=%0h exp 0",
                     err_seen, err_expected, err_received);
        end
    endtask

    task automatic test_tx_stream();
        do_reset();
        tx_enable = 1'b1;
        fifo_out_ready = 1'b1;
        tick();
        checks++;
        if (fifo_out_valid !== 1'b1) begin
            fails++;
            $display("FAIL tx_first_valid got=%b exp=1", fifo_out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (fifo_out_valid !== 1'b1 || fifo_out_data !== W'(i)) begin
                fails++;
                $display("FAIL tx_stream[%0d] got v=%b d=%0h exp v=1 d=%0h",
                         i, fifo_out_valid, fifo_out_data, i);
            end
            tx_enable = (i < 9);
            tick();
        end
        checks++;
        if (tx_count !== 32'd10 || fifo_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL tx_stream_end got cnt=%0d v=%b exp cnt=10 v=0",
                     tx_count, fifo_out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        tx_enable = 1'b1;
        fifo_out_ready = 1'b0;
        tick();
        held = m_tx_val;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (fifo_out_valid !== 1'b1 || fifo_out_data !== held) begin
                fails++;
                $display("FAIL bp_hold[%0d] got v=%b d=%0h exp v=1 d=%0h",
                         c, fifo_out_valid, fifo_out_data, held);
            end
            if (c == 2) tx_enable = 1'b0;
            if (c == 3) tx_enable = 1'b1;
            tick();
        end
        fifo_out_ready = 1'b1;
        tick();
        checks++;
        if (fifo_out_valid !== 1'b0 || tx_count !== m_tx_cnt) begin
            fails++;
            $display("FAIL bp_drain got v=%b cnt=%0d exp v=0 cnt=%0d",
                     fifo_out_valid, tx_count, m_tx_cnt);
        end
        tick();
        checks++;
        if (fifo_out_valid !== 1'b1 || fifo_out_data !== held + 1'b1) begin
            fails++;
            $display("FAIL bp_resume got v=%b d=%0h exp v=1 d=%0h",
                     fifo_out_valid, fifo_out_data, held + 1'b1);
        end
        tx_enable = 1'b0;
        tick();
    endtask

    task automatic test_rx_clean();
        do_reset();
        rx_enable = 1'b1;
        tick();
        checks++;
        if (fifo_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rx_ready got=%b exp=1", fifo_in_ready);
        end
        rx_push(16'h0005);
        rx_push(16'h0006);
        rx_push(16'h0007);
        checks++;
        if (rx_count !== 32'd3 || err_count !== 0 || err_seen !== 1'b0) begin
            fails++;
            $display("FAIL rx_clean got cnt=%0d err=%0d s=%b exp 3 0 0",
                     rx_count, err_count, err_seen);
        end
    endtask

    task automatic test_rx_mismatch();
        do_reset();
        tick();
        rx_push(16'd10);
        rx_push(16'd11);
        rx_push(16'd20);
        rx_push(16'd21);
        rx_push(16'd30);
        checks++;
        if (err_count !== 4'd2 || rx_count !== 32'd5 || err_seen !== 1'b1) begin
            fails++;
            $display("FAIL rx_mis_cnt got err=%0d cnt=%0d s=%b exp 2 5 1",
                     err_count, rx_count, err_seen);
        end
        checks++;
        if (err_expected !== 16'd12 || err_received !== 16'd20) begin
            fails++;
            $display("FAIL rx_mis_cap got e=%0d r=%0d exp e=12 r=20",
                     err_expected, err_received);
        end
    endtask

    task automatic test_rx_wrap();
        do_reset();
        tick();
        rx_push(16'hFFFE);
        rx_push(16'hFFFF);
        rx_push(16'h0000);
        rx_push(16'h0001);
        checks++;
        if (err_count !== 0 || rx_count !== 32'd4 || err_seen !== 1'b0) begin
            fails++;
            $display("FAIL rx_wrap got err=%0d cnt=%0d s=%b exp 0 4 0",
                     err_count, rx_count, err_seen);
        end
    endtask

    task automatic test_rx_saturate();
        do_reset();
        tick();
        for (int i = 0; i < 21; i++) rx_push(W'(2 * i));
        checks++;
        if (err_count !== {EW{1'b1}} || rx_count !== 32'd21) begin
            fails++;
            $display("FAIL rx_sat got err=%0d cnt=%0d exp err=15 cnt=21",
                     err_count, rx_count);
        end
        checks++;
        if (err_expected !== 16'd1 || err_received !== 16'd2) begin
            fails++;
            $display("FAIL rx_sat_cap got e=%0d r=%0d exp e=1 r=2",
                     err_expected, err_received);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rx_enable = 1'b1;
        tx_enable = 1'b1;
        fifo_out_ready = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) tick();
        rx_push(16'd50);
        fifo_out_ready = 1'b0;
        tick();
        checks++;
        if (fifo_out_valid !== 1'b1 || fifo_out_data !== m_tx_val) begin
            fails++;
            $display("FAIL mid_stall got v=%b d=%0h exp v=1 d=%0h",
                     fifo_out_valid, fifo_out_data, m_tx_val);
        end
        do_reset();
        checks++;
        if (fifo_out_valid !== 1'b0 || tx_count !== 0 || rx_count !== 0 ||
            err_count !== 0) begin
            fails++;
            $display("FAIL mid_rst got v=%b tx=%0d rx=%0d err=%0d exp 0",
                     fifo_out_valid, tx_count, rx_count, err_count);
        end
        fifo_out_ready = 1'b1;
        tick();
        checks++;
        if (fifo_out_valid !== 1'b1 || fifo_out_data !== 16'd0) begin
            fails++;
            $display("FAIL mid_restart got v=%b d=%0h exp v=1 d=0",
                     fifo_out_valid, fifo_out_data);
        end
        rx_push(16'd100);
        checks++;
        if (rx_count !== 32'd1 || err_count !== 0 || err_seen !== 1'b0) begin
            fails++;
            $display("FAIL mid_hunt got cnt=%0d err=%0d s=%b exp 1 0 0",
                     rx_count, err_count, err_seen);
        end
        tx_enable = 1'b0;
        rx_enable = 1'b0;
        tick();
    endtask

    task automatic test_random_traffic();
        int bad = 0;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            tx_enable      = ($urandom_range(0, 99) < 70);
            fifo_out_ready = ($urandom_range(0, 99) < 60);
            rx_enable      = ($urandom_range(0, 99) < 80);
            fifo_in_valid  = ($urandom_range(0, 99) < 70);
            fifo_in_data   = ($urandom_range(0, 99) < 90) ?
                             m_exp : W'($urandom);
            tick();
            checks++;
            if (fifo_out_valid !== m_valid ||
                (m_valid && fifo_out_data !== m_tx_val) ||
                tx_count !== m_tx_cnt) begin
                fails++;
                bad++;
                if (bad < 10)
                    $display("FAIL rnd_tx[%0d] got v=%b d=%0h c=%0d exp v=%b d=%0h c=%0d",
                             c, fifo_out_valid, fifo_out_data, tx_count,
                             m_valid, m_tx_val, m_tx_cnt);
            end
            checks++;
            if (fifo_in_ready !== m_ready || rx_count !== m_rx_cnt ||
                err_count !== m_err || err_seen !== m_seen ||
                err_expected !== m_eexp || err_received !== m_ercv) begin
                fails++;
                bad++;
                if (bad < 10)
                    $display("FAIL rnd_rx[%0d] got r=%b c=%0d e=%0d s=%b ee=%0h er=%0h exp r=%b c=%0d e=%0d s=%b ee=%0h er=%0h",
                             c, fifo_in_ready, rx_count, err_count, err_seen,
                             err_expected, err_received, m_ready, m_rx_cnt,
                             m_err, m_seen, m_eexp, m_ercv);
            end
        end
        fifo_in_valid = 1'b0;
        tx_enable = 1'b0;
        rx_enable = 1'b0;
    endtask

    task automatic test_tx_wrap();
        do_reset();
        tx_enable = 1'b1;
        fifo_out_ready = 1'b1;
        tick();
        for (int i = 0; i < 65534; i++) tick();
        checks++;
        if (fifo_out_data !== 16'hFFFE || tx_count !== 32'd65534) begin
            fails++;
            $display("FAIL tx_wrap_pre got d=%0h c=%0d exp d=fffe c=65534",
                     fifo_out_data, tx_count);
        end
        tick();
        checks++;
        if (fifo_out_valid !== 1'b1 || fifo_out_data !== 16'hFFFF) begin
            fails++;
            $display("FAIL tx_wrap_ffff got v=%b d=%0h exp v=1 d=ffff",
                     fifo_out_valid, fifo_out_data);
        end
        tick();
        checks++;
        if (fifo_out_valid !== 1'b1 || fifo_out_data !== 16'h0000 ||
            fifo_out_data !== m_tx_val) begin
            fails++;
            $display("FAIL tx_wrap_zero got v=%b d=%0h exp v=1 d=0",
                     fifo_out_valid, fifo_out_data);
        end
        tx_enable = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_tx_stream();
        test_backpressure();
        test_rx_clean();
        test_rx_mismatch();
        test_rx_wrap();
        test_rx_saturate();
        test_reset_mid();
        test_random_traffic();
        test_tx_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/glip_pattern_endpoint.md
Name: glip_pattern_endpoint

Overview:
- Logic-side traffic endpoint for the GLIP FIFO interface. It replaces the plain loopback wire in board demos.
- TX half drives the Logic->Host FIFO (fifo_out_*) with an incrementing counter pattern.
- RX half consumes the Host->Logic FIFO (fifo_in_*), checks the data against an incrementing sequence, and counts mismatches.
- Lets the host measure throughput and data integrity in each direction independently.

Parameters:
- WIDTH, 16, data word width; matches the GLIP backend WIDTH.
- ERR_WIDTH, 16, width of the saturating error counter.

Ports:
- clk  in  1  system clock; same clock as the GLIP backend.
- rst  in  1  synchronous, active-high reset. Typically driven by ctrl_logic_rst.
- tx_enable  in  1  allows the TX generator to start new words.
- rx_enable  in  1  allows the RX checker to accept words.
- fifo_out_valid  out  1  Logic->Host word valid.
- fifo_out_data  out  WIDTH  Logic->Host word.
- fifo_out_ready  in  1  Logic->Host backend ready.
- fifo_in_valid  in  1  Host->Logic word valid.
- fifo_in_data  in  WIDTH  Host->Logic word.
- fifo_in_ready  out  1  Host->Logic accept.
- tx_count  out  32  number of TX words transferred.
- rx_count  out  32  number of RX words transferred.
- err_count  out  ERR_WIDTH  number of RX mismatches.
- err_seen  out  1  sticky flag; set on the first mismatch.
- err_expected  out  WIDTH  expected value at the first mismatch.
- err_received  out  WIDTH  received value at the first mismatch.

Behaviour:
- General
  - All state is updated on the rising edge of clk.
  - rst has priority over all other inputs and takes effect on the edge where it is sampled high.
  - A transfer occurs on any cycle where valid && ready are both high.
- Reset values
  - fifo_out_valid=0, fifo_out_data=0, fifo_in_ready=0.
  - tx_count=0, rx_count=0, err_count=0, err_seen=0, err_expected=0, err_received=0.
  - TX state = IDLE, RX state = HUNT, internal TX value = 0.
- TX FSM, states IDLE / SEND / DRAIN
  - IDLE: if tx_enable=1, go to SEND and set fifo_out_valid=1 with data = the internal TX value. First valid appears 1 cycle after tx_enable is sampled.
  - SEND, on transfer: tx_count+1; data+1, wrapping modulo 2^WIDTH. The next word is presented back-to-back in the following cycle, giving 1 word/cycle at full throughput.
  - SEND, tx_enable=0 with no transfer this cycle: go to DRAIN. Valid stays high and data stays stable, because valid must never drop before acceptance.
  - SEND, tx_enable=0 with a transfer this cycle: go to IDLE with valid=0 and the value incremented.
  - DRAIN: hold valid and data until a transfer occurs, then go to IDLE with valid=0 and the value incremented.
  - fifo_out_data never changes while valid=1 and ready=0.
  - Sequence continuity: the pattern continues across enable toggles and resets only on rst.
- RX datapath
  - fifo_in_ready is a register equal to rx_enable delayed by one cycle. The ready=0 cycles after rx_enable drops ignore valid.
- RX FSM, states HUNT / TRACK
  - HUNT, first transfer: take the word as the seed, expected = word+1 (mod 2^WIDTH), rx_count+1, go to TRACK. The seed word is never counted as an error.
  - TRACK, transfer with data == expected: rx_count+1, expected+1.
  - TRACK, transfer with data != expected: rx_count+1; err_count+1, saturating at 2^ERR_WIDTH-1; resync expected = data+1.
  - First mismatch only: if err_seen=0, set err_seen=1 and capture err_expected and err_received. Later mismatches do not overwrite the captures.
- Counter wrap
  - tx_count and rx_count wrap modulo 2^32.
  - Expected and TX values wrap at all-ones to 0 without an error, e.g. 0xFFFF followed by 0x0000 is valid.
- Independence and ordering
  - TX and RX are fully independent.
  - A simultaneous TX and RX transfer in the same cycle each update their own counters.
- Reset mid-operation
  - Valid drops at the next edge even if a word was not accepted. The backend is reset together with this block.
  - The next TX word after reset is 0.
  - RX returns to HUNT.

Test Plan:
- Reset, then tx_enable=1 with fifo_out_ready=1 constant: valid rises 1 cycle after enable. Data reads 0,1,2,…,9 over 10 consecutive cycles, and tx_count=10.
- Backpressure: ready=0 for 5 cycles while valid=1 with data=3. Data stays 3 for all 5 cycles. Dropping tx_enable during the stall keeps valid=1 until ready, then valid=0; the next enable resumes at 4.
- RX clean stream: rx_enable=1, send 0x0005,0x0006,0x0007 with valid continuous. Result: rx_count=3, err_count=0, err_seen=0.
- RX mismatch: send 10,11,20,21,30. Result: err_count=2, err_seen=1, err_expected=12, err_received=20, rx_count=5.
- Wrap: send 0xFFFE,0xFFFF,0x0000,0x0001 (WIDTH=16) -> err_count=0. TX started at 0xFFFE (via 65534 prior transfers or force) -> emits 0xFFFF then 0x0000.
- Reset mid-stall: valid=1 with data=7 and ready=0, assert rst for 1 cycle. Next edge: valid=0 and all counters 0. After re-enable, first data=0, and RX is back in HUNT (the first word is accepted with no error).
